inst_stream_loader: RTL and testbench

//   Consumes the UART RX byte stream during LOAD_ST and writes 32-bit instruction words

---
 rtl/inst_stream_loader_pkg.sv | 17 +
 rtl/inst_stream_loader_if.sv | 26 ++
 rtl/inst_stream_loader_byte_packer.sv | 41 ++++
 rtl/inst_stream_loader.sv | 170 +++++++++++++++++
 tb/tb_inst_stream_loader.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_stream_loader_pkg.sv
// Shared types and constants for the instruction stream loader.
package inst_stream_loader_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HDR  = 3'd1,
      BODY = 3'd2,
      DONE = 3'd3,
      ERR  = 3'd4
   } loader_state_t;

   localparam int         WORD_BYTES = 4;
   localparam int         BYTE_IDX_W = $clog2(WORD_BYTES);
   localparam logic [3:0] WE_ALL     = 4'hF;
   localparam logic [3:0] WE_NONE    = 4'h0;

endpackage

// File: rtl/inst_stream_loader_if.sv
// Byte stream input and instruction BRAM port-A write bus of the loader.
interface inst_stream_loader_if;

   logic [7:0]  data;
   logic        en;
   logic [31:0] inst_addra;
   logic [31:0] inst_dina;
   logic [3:0]  inst_wea;

   modport master (
      input  data,
      input  en,
      output inst_addra,
      output inst_dina,
      output inst_wea
   );

   modport slave (
      output data,
      output en,
      input  inst_addra,
      input  inst_dina,
      input  inst_wea
   );

endinterface

// File: rtl/inst_stream_loader_byte_packer.sv
// Big-endian 8->32 assembler: o_word/o_last are valid in the cycle the last byte is strobed,
// so the caller registers the word into its own staging register on that edge.
module inst_stream_loader_byte_packer
   import inst_stream_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        clear,
   input  logic [7:0]  i_data,
   input  logic        i_en,
   output logic [31:0] o_word,
   output logic        o_last
);

   localparam int                    SHIFT_W  = 8 * (WORD_BYTES - 1);
   localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(WORD_BYTES - 1);

   logic [SHIFT_W-1:0]    r_shift;
   logic [BYTE_IDX_W-1:0] r_byte_idx;

   // Shift in leading bytes; the index wraps to zero after the last byte of a word.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_shift    <= '0;
         r_byte_idx <= '0;
      end else if (clear) begin
         r_shift    <= '0;
         r_byte_idx <= '0;
      end else if (i_en) begin
         r_shift    <= {r_shift[SHIFT_W-9:0], i_data};
         r_byte_idx <= r_byte_idx + BYTE_IDX_W'(1);
      end else begin
         r_shift    <= r_shift;
         r_byte_idx <= r_byte_idx;
      end
   end

   assign o_word = {r_shift, i_data};
   assign o_last = i_en && (r_byte_idx == LAST_IDX);

endmodule

// File: rtl/inst_stream_loader.sv
// Loads a length-prefixed big-endian word stream into instruction BRAM port A and
// reports completion or an oversize header.
module inst_stream_loader
   import inst_stream_loader_pkg::*;
#(
   parameter int DEPTH_WORDS = 16384,
   parameter int CNT_W       = 32
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 clear,
   inst_stream_loader_if.master bus,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [CNT_W-1:0]     word_cnt
);

   loader_state_t    r_state;
   loader_state_t    w_state_next;
   logic             r_busy, r_done, r_err;
   logic             w_busy_next, w_done_next, w_err_next;
   logic [CNT_W-1:0] r_len;
   logic [CNT_W-1:0] r_word_cnt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic [31:0]      r_addra;
   logic [31:0]      r_dina;
   logic [3:0]       r_wea;
   logic             w_len_ld;
   logic             w_wr;
   logic             w_pk_en;
   logic [31:0]      w_word;
   logic             w_last;
   logic [CNT_W-1:0] w_hdr_len;

   assign w_pk_en   = bus.en && !clear &&
                      ((r_state == IDLE) || (r_state == HDR) || (r_state == BODY));
   assign w_hdr_len = CNT_W'(w_word);
   assign w_cnt_inc = r_word_cnt + CNT_W'(1);

   inst_stream_loader_byte_packer u_packer (
      .clk    (clk),
      .rstn   (rstn),
      .clear  (clear),
      .i_data (bus.data),
      .i_en   (w_pk_en),
      .o_word (w_word),
      .o_last (w_last)
   );

   // State, status flags and header length.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_len   <= '0;
      end else begin
         r_state <= w_state_next;
         r_busy  <= w_busy_next;
         r_done  <= w_done_next;
         r_err   <= w_err_next;
         r_len   <= w_len_ld ? w_hdr_len : r_len;
      end
   end

   // Next state; on the final body write the state moves to DONE one cycle before done rises.
   always_comb begin
      w_state_next = r_state;
      w_busy_next  = r_busy;
      w_done_next  = r_done;
      w_err_next   = r_err;
      w_len_ld     = 1'b0;
      w_wr         = 1'b0;
      if (clear) begin
         w_state_next = IDLE;
         w_busy_next  = 1'b0;
         w_done_next  = 1'b0;
         w_err_next   = 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.en) begin
                  w_state_next = HDR;
                  w_busy_next  = 1'b1;
               end else begin
                  w_state_next = IDLE;
               end
            end
            HDR: begin
               if (w_last) begin
                  w_len_ld = 1'b1;
                  if (w_hdr_len == '0) begin
                     w_state_next = DONE;
                     w_done_next  = 1'b1;
                     w_busy_next  = 1'b0;
                  end else if (w_hdr_len > CNT_W'(DEPTH_WORDS)) begin
                     w_state_next = ERR;
                     w_err_next   = 1'b1;
                     w_busy_next  = 1'b0;
                  end else begin
                     w_state_next = BODY;
                  end
               end else begin
                  w_state_next = HDR;
               end
            end
            BODY: begin
               if (w_last) begin
                  w_wr = 1'b1;
                  if (w_cnt_inc == r_len) begin
                     w_state_next = DONE;
                  end else begin
                     w_state_next = BODY;
                  end
               end else begin
                  w_state_next = BODY;
               end
            end
            DONE: begin
               w_done_next = 1'b1;
               w_busy_next = 1'b0;
            end
            ERR: begin
               w_err_next  = 1'b1;
               w_busy_next = 1'b0;
            end
            default: begin
               w_state_next = IDLE;
               w_busy_next  = 1'b0;
            end
         endcase
      end
   end

   // BRAM port drive: address/data hold between writes, the write strobe lasts one cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_addra    <= 32'h0;
         r_dina     <= 32'h0;
         r_wea      <= WE_NONE;
         r_word_cnt <= '0;
      end else if (clear) begin
         r_addra    <= r_addra;
         r_dina     <= r_dina;
         r_wea      <= WE_NONE;
         r_word_cnt <= '0;
      end else if (w_wr) begin
         r_addra    <= 32'({r_word_cnt, {BYTE_IDX_W{1'b0}}});
         r_dina     <= w_word;
         r_wea      <= WE_ALL;
         r_word_cnt <= w_cnt_inc;
      end else begin
         r_addra    <= r_addra;
         r_dina     <= r_dina;
         r_wea      <= WE_NONE;
         r_word_cnt <= r_word_cnt;
      end
   end

   assign bus.inst_addra = r_addra;
   assign bus.inst_dina  = r_dina;
   assign bus.inst_wea   = r_wea;
   assign busy           = r_busy;
   assign done           = r_done;
   assign err            = r_err;
   assign word_cnt       = r_word_cnt;

endmodule

// File: tb/tb_inst_stream_loader.sv
// Directed bench for inst_stream_loader: per-cycle vector table plus hand-written sequences.
module tb_inst_stream_loader;

   logic        clk;
   logic        rstn;
   logic        clear;
   logic        busy, done, err;
   logic [31:0] word_cnt;

   inst_stream_loader_if bus ();

   inst_stream_loader #(.DEPTH_WORDS(16384), .CNT_W(32)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .clear    (clear),
      .bus      (bus.master),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .word_cnt (word_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  d;
      logic        en;
      logic        clr;
      logic [3:0]  wea;
      logic [31:0] addr;
      logic [31:0] dina;
      logic        busy;
      logic        done;
      logic        err;
      logic [31:0] cnt;
   } vec_t;

   vec_t        tv[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];
   int          bad_wea = 0;

   // Write monitor: records every BRAM write seen between clock edges.
   always @(negedge clk) begin
      if (bus.inst_wea !== 4'h0) begin
         wr_addr.push_back(bus.inst_addra);
         wr_data.push_back(bus.inst_dina);
         if (bus.inst_wea !== 4'hF) bad_wea++;
      end
   end

   task automatic add(input logic [7:0] d, input logic en, input logic clr, input logic [3:0] wea,
                      input logic [31:0] addr, input logic [31:0] dina, input logic b,
                      input logic dn, input logic er, input logic [31:0] cnt);
      vec_t v;
      v.d = d; v.en = en; v.clr = clr; v.wea = wea; v.addr = addr; v.dina = dina;
      v.busy = b; v.done = dn; v.err = er; v.cnt = cnt;
      tv.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      repeat (gap) begin
         @(negedge clk);
         bus.en = 1'b0;
      end
      @(negedge clk);
      bus.data = b;
      bus.en   = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.en = 1'b0;
      end
   endtask

   task automatic pulse_clear(input logic with_en, input logic [7:0] b);
      @(negedge clk);
      clear    = 1'b1;
      bus.en   = with_en;
      bus.data = b;
      @(negedge clk);
      clear  = 1'b0;
      bus.en = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int maxgap);
      logic [31:0] t;
      t = w;
      for (int k = 0; k < 4; k++) begin
         send_byte(t[31:24], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
         t = t << 8;
      end
   endtask

   initial begin
      logic [31:0] t4_words [3];
      logic        ok;

      // Test 1: N=2, en every cycle, then en in DONE and clear
      add(8'h00,1,0,4'h0,32'h0,32'h0,1,0,0,0);
      add(8'h00,1,0,4'h0,32'h0,32'h0,1,0,0,0);
      add(8'h00,1,0,4'h0,32'h0,32'h0,1,0,0,0);
      add(8'h02,1,0,4'h0,32'h0,32'h0,1,0,0,0);
      add(8'h11,1,0,4'h0,32'h0,32'h0,1,0,0,0);
      add(8'h22,1,0,4'h0,32'h0,32'h0,1,0,0,0);
      add(8'h33,1,0,4'h0,32'h0,32'h0,1,0,0,0);
      add(8'h44,1,0,4'hF,32'h0,32'h11223344,1,0,0,1);
      add(8'hAA,1,0,4'h0,32'h0,32'h11223344,1,0,0,1);
      add(8'hBB,1,0,4'h0,32'h0,32'h11223344,1,0,0,1);
      add(8'hCC,1,0,4'h0,32'h0,32'h11223344,1,0,0,1);
      add(8'hDD,1,0,4'hF,32'h4,32'hAABBCCDD,1,0,0,2);
      add(8'h00,0,0,4'h0,32'h4,32'hAABBCCDD,0,1,0,2);
      add(8'h55,1,0,4'h0,32'h4,32'hAABBCCDD,0,1,0,2);
      add(8'h00,0,1,4'h0,32'h4,32'hAABBCCDD,0,0,0,0);
      // Test 2: zero-length header
      add(8'h00,1,0,4'h0,32'h4,32'hAABBCCDD,1,0,0,0);
      add(8'h00,1,0,4'h0,32'h4,32'hAABBCCDD,1,0,0,0);
      add(8'h00,1,0,4'h0,32'h4,32'hAABBCCDD,1,0,0,0);
      add(8'h00,1,0,4'h0,32'h4,32'hAABBCCDD,0,1,0,0);
      add(8'h77,1,0,4'h0,32'h4,32'hAABBCCDD,0,1,0,0);
      add(8'h00,0,1,4'h0,32'h4,32'hAABBCCDD,0,0,0,0);
      // Test 3: header DEPTH_WORDS+1 -> error, later bytes ignored
      add(8'h00,1,0,4'h0,32'h4,32'hAABBCCDD,1,0,0,0);
      add(8'h00,1,0,4'h0,32'h4,32'hAABBCCDD,1,0,0,0);
      add(8'h40,1,0,4'h0,32'h4,32'hAABBCCDD,1,0,0,0);
      add(8'h01,1,0,4'h0,32'h4,32'hAABBCCDD,0,0,1,0);
      add(8'h12,1,0,4'h0,32'h4,32'hAABBCCDD,0,0,1,0);
      add(8'h00,0,1,4'h0,32'h4,32'hAABBCCDD,0,0,0,0);
      // Header exactly DEPTH_WORDS is accepted; clear on a 4th body byte drops the write
      add(8'h00,1,0,4'h0,32'h4,32'hAABBCCDD,1,0,0,0);
      add(8'h00,1,0,4'h0,32'h4,32'hAABBCCDD,1,0,0,0);
      add(8'h40,1,0,4'h0,32'h4,32'hAABBCCDD,1,0,0,0);
      add(8'h00,1,0,4'h0,32'h4,32'hAABBCCDD,1,0,0,0);
      add(8'h01,1,0,4'h0,32'h4,32'hAABBCCDD,1,0,0,0);
      add(8'h02,1,0,4'h0,32'h4,32'hAABBCCDD,1,0,0,0);
      add(8'h03,1,0,4'h0,32'h4,32'hAABBCCDD,1,0,0,0);
      add(8'h04,1,1,4'h0,32'h4,32'hAABBCCDD,0,0,0,0);
      // Test 6 tail: fresh N=1 session after clear
      add(8'h00,1,0,4'h0,32'h4,32'hAABBCCDD,1,0,0,0);
      add(8'h00,1,0,4'h0,32'h4,32'hAABBCCDD,1,0,0,0);
      add(8'h00,1,0,4'h0,32'h4,32'hAABBCCDD,1,0,0,0);
      add(8'h01,1,0,4'h0,32'h4,32'hAABBCCDD,1,0,0,0);
      add(8'h01,1,0,4'h0,32'h4,32'hAABBCCDD,1,0,0,0);
      add(8'h02,1,0,4'h0,32'h4,32'hAABBCCDD,1,0,0,0);
      add(8'h03,1,0,4'h0,32'h4,32'hAABBCCDD,1,0,0,0);
      add(8'h04,1,0,4'hF,32'h0,32'h01020304,1,0,0,1);
      add(8'h00,0,0,4'h0,32'h0,32'h01020304,0,1,0,1);

      rstn     = 1'b0;
      clear    = 1'b0;
      bus.en   = 1'b0;
      bus.data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_wea",  {28'h0, bus.inst_wea}, 32'h0);
      chk("reset_addr", bus.inst_addra, 32'h0);
      chk("reset_dina", bus.inst_dina, 32'h0);
      chk("reset_flags", {29'h0, busy, done, err}, 32'h0);
      chk("reset_cnt",  word_cnt, 32'h0);
      @(negedge clk);
      rstn = 1'b1;

      for (int i = 0; i < tv.size(); i++) begin
         @(negedge clk);
         bus.data = tv[i].d;
         bus.en   = tv[i].en;
         clear    = tv[i].clr;
         @(posedge clk);
         #1;
         ok = (bus.inst_wea === tv[i].wea) && (bus.inst_addra === tv[i].addr) &&
              (bus.inst_dina === tv[i].dina) && (busy === tv[i].busy) &&
              (done === tv[i].done) && (err === tv[i].err) && (word_cnt === tv[i].cnt);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL vec%0d: got wea=%h addr=%h dina=%h busy=%b done=%b err=%b cnt=%0d expected wea=%h addr=%h dina=%h busy=%b done=%b err=%b cnt=%0d",
                     i, bus.inst_wea, bus.inst_addra, bus.inst_dina, busy, done, err, word_cnt,
                     tv[i].wea, tv[i].addr, tv[i].dina, tv[i].busy, tv[i].done, tv[i].err, tv[i].cnt);
         end
      end
      @(negedge clk);
      bus.en = 1'b0;
      clear  = 1'b0;

      // Test 4: N=3 with random inter-byte gaps
      t4_words[0] = 32'h0BADF00D;
      t4_words[1] = 32'h12345678;
      t4_words[2] = 32'hCAFEF00D;
      pulse_clear(1'b0, 8'h00);
      wr_addr.delete();
      wr_data.delete();
      send_word(32'h00000003, 20);
      for (int w = 0; w < 3; w++) send_word(t4_words[w], 20);
      idle(4);
      chk("t4_nwrites", 32'(wr_addr.size()), 32'd3);
      for (int w = 0; w < 3 && w < wr_addr.size(); w++) begin
         chk("t4_addr", wr_addr[w], 32'(w * 4));
         chk("t4_data", wr_data[w], t4_words[w]);
      end
      chk("t4_done", {31'h0, done}, 32'h1);
      chk("t4_cnt",  word_cnt, 32'd3);
      chk("t4_busy", {31'h0, busy}, 32'h0);

      // Test 5: async reset mid-word, then a fresh single-word stream
      pulse_clear(1'b0, 8'h00);
      send_word(32'h00000002, 0);
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      @(negedge clk);
      bus.en = 1'b0;
      rstn   = 1'b0;
      #2;
      chk("t5_rst_addr", bus.inst_addra, 32'h0);
      chk("t5_rst_dina", bus.inst_dina, 32'h0);
      chk("t5_rst_flags", {29'h0, busy, done, err}, 32'h0);
      @(negedge clk);
      rstn = 1'b1;
      wr_addr.delete();
      wr_data.delete();
      send_word(32'h00000001, 0);
      send_word(32'hDEADBEEF, 0);
      idle(3);
      chk("t5_nwrites", 32'(wr_addr.size()), 32'd1);
      if (wr_addr.size() > 0) begin
         chk("t5_addr", wr_addr[0], 32'h0);
         chk("t5_data", wr_data[0], 32'hDEADBEEF);
      end
      chk("t5_done", {31'h0, done}, 32'h1);
      chk("t5_cnt",  word_cnt, 32'd1);

      // clear together with en: the byte must not become header byte 0
      pulse_clear(1'b1, 8'hFF);
      wr_addr.delete();
      wr_data.delete();
      send_word(32'h00000001, 0);
      send_word(32'hCAFEBABE, 0);
      idle(3);
      chk("clr_en_err",  {31'h0, err}, 32'h0);
      chk("clr_en_done", {31'h0, done}, 32'h1);
      chk("clr_en_nwrites", 32'(wr_addr.size()), 32'd1);
      if (wr_addr.size() > 0) begin
         chk("clr_en_addr", wr_addr[0], 32'h0);
         chk("clr_en_data", wr_data[0], 32'hCAFEBABE);
      end
      chk("wea_only_full", 32'(bad_wea), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
